// File: rtl/resp_sched.sv
// resp_sched: collects register-file and ALU responses into a small byte
// FIFO and hands them one at a time to a UART transmitter, pacing each byte
// on the transmitter's Busy handshake (with a timeout if Busy never rises).

module resp_sched #(
    parameter int WIDTH         = 8,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int DEPTH         = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     OUT_Valid,
    input  logic [WIDTH-1:0]         RdData,
    input  logic                     RdData_Valid,
    input  logic                     Busy,
    output logic [WIDTH-1:0]         TX_P_Data,
    output logic                     TX_D_VALID,
    output logic                     Q_Full,
    output logic                     Overflow
);

    // Pointer width wraps naturally because DEPTH is a power of two; the
    // count needs one extra value so that a completely full queue is visible.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       timeout_cnt;
    logic [WIDTH-1:0] last_byte;

    logic             pop;
    logic [CNT_W-1:0] free_slots;
    logic [CNT_W-1:0] free_after_rd;
    logic             rd_accept;
    logic             alu_accept;
    logic             drop;
    logic [PTR_W-1:0] alu_lo_ptr;
    logic [PTR_W-1:0] alu_hi_ptr;
    logic [1:0]       push_cnt;

    // Admission: the byte leaving this cycle frees its slot, read data claims
    // space before the ALU pair, and the ALU pair goes in whole or not at all.
    always_comb begin
        pop           = (state == SEND);
        free_slots    = DEPTH_C - count + CNT_W'(pop);
        rd_accept     = RdData_Valid && (free_slots != '0);
        free_after_rd = free_slots - CNT_W'(rd_accept);
        alu_accept    = OUT_Valid && (free_after_rd >= TWO_C);
        drop          = (RdData_Valid && !rd_accept) || (OUT_Valid && !alu_accept);
        alu_lo_ptr    = wr_ptr + PTR_W'(rd_accept);
        alu_hi_ptr    = alu_lo_ptr + PTR_W'(1);
        push_cnt      = {1'b0, rd_accept} + (alu_accept ? 2'd2 : 2'd0);
    end

    // Storage array: read data lands first, the ALU low byte next, then the
    // high byte, so the transmit order matches arrival order within a cycle.
    always_ff @(posedge CLK) begin
        if (rd_accept) begin
            mem[wr_ptr] <= RdData;
        end
        if (alu_accept) begin
            mem[alu_lo_ptr] <= ALU_OUT[WIDTH-1:0];
            mem[alu_hi_ptr] <= ALU_OUT[2*WIDTH-1:WIDTH];
        end
    end

    // Pointers and occupancy move by pushes minus pops in the same edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push_cnt) - CNT_W'(pop);
        end
    end

    // Overflow latches on the first discarded response and stays until reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Overflow <= 1'b0;
        end else if (drop) begin
            Overflow <= 1'b1;
        end
    end

    // Counts consecutive quiet cycles while waiting for the transmitter to
    // pick the byte up; any other state or a Busy cycle restarts it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            timeout_cnt <= '0;
        end else if ((state == WAIT_BUSY) && !Busy) begin
            timeout_cnt <= timeout_cnt + 4'd1;
        end else begin
            timeout_cnt <= '0;
        end
    end

    // Remembers the byte most recently strobed so the data bus stays stable
    // between strobes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_byte <= '0;
        end else if (state == SEND) begin
            last_byte <= mem[rd_ptr];
        end
    end

    // Issue FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Issue FSM transitions: strobe one byte, then wait for the transmitter
    // to go busy and idle again (or give up after sixteen quiet cycles).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if ((count != '0) && !Busy) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                next_state = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (Busy) begin
                    next_state = WAIT_DONE;
                end else if (timeout_cnt == 4'hF) begin
                    next_state = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!Busy) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs: the strobe is only high in SEND, where the head byte is shown.
    always_comb begin
        TX_D_VALID = (state == SEND);
        TX_P_Data  = (state == SEND) ? mem[rd_ptr] : last_byte;
        Q_Full     = (count == DEPTH_C);
    end

endmodule

// File: tb/tb_resp_sched.sv
// tb_resp_sched: directed and randomized stimulus for resp_sched, with a
// transfer-level reference model feeding an expected-byte scoreboard.

module tb_resp_sched;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] ALU_OUT = '0;
    logic        OUT_Valid = 1'b0;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic        Busy;
    logic [7:0]  TX_P_Data;
    logic        TX_D_VALID;
    logic        Q_Full;
    logic        Overflow;

    logic man_busy = 1'b0;
    logic emu_busy = 1'b0;
    logic uart_auto = 1'b0;

    int checks = 0;
    int failures = 0;
    bit checking_en = 1'b0;

    logic [7:0] exp_q[$];

    int m_count = 0;
    int m_quiet = 0;
    bit m_strobe = 1'b0;
    bit m_inflight = 1'b0;
    bit m_saw_busy = 1'b0;
    bit m_overflow = 1'b0;
    int m_free;
    int m_push;
    int m_old_count;
    bit m_popped;

    int emu_delay;
    int emu_len;
    bit emu_silent;

    assign Busy = uart_auto ? emu_busy : man_busy;

    resp_sched #(
        .WIDTH(8),
        .ALU_OUT_WIDTH(16),
        .DEPTH(DEPTH)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .ALU_OUT(ALU_OUT),
        .OUT_Valid(OUT_Valid),
        .RdData(RdData),
        .RdData_Valid(RdData_Valid),
        .Busy(Busy),
        .TX_P_Data(TX_P_Data),
        .TX_D_VALID(TX_D_VALID),
        .Q_Full(Q_Full),
        .Overflow(Overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        failures++;
        $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a byte list plus a transfer-level view of the UART
    // handshake (strobe, then either Busy high-then-low or 16 quiet cycles).
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_count    = 0;
            m_quiet    = 0;
            m_strobe   = 1'b0;
            m_inflight = 1'b0;
            m_saw_busy = 1'b0;
            m_overflow = 1'b0;
            exp_q.delete();
        end else begin
            m_popped    = m_strobe;
            m_old_count = m_count;
            m_free      = DEPTH - m_count + (m_popped ? 1 : 0);
            m_push      = 0;
            if (RdData_Valid) begin
                if (m_free >= 1) begin
                    exp_q.push_back(RdData);
                    m_free = m_free - 1;
                    m_push = m_push + 1;
                end else begin
                    m_overflow = 1'b1;
                end
            end
            if (OUT_Valid) begin
                if (m_free >= 2) begin
                    exp_q.push_back(ALU_OUT[7:0]);
                    exp_q.push_back(ALU_OUT[15:8]);
                    m_push = m_push + 2;
                end else begin
                    m_overflow = 1'b1;
                end
            end
            m_count = m_count + m_push - (m_popped ? 1 : 0);

            if (m_popped) begin
                m_strobe   = 1'b0;
                m_inflight = 1'b1;
                m_saw_busy = 1'b0;
                m_quiet    = 0;
            end else if (m_inflight) begin
                if (!m_saw_busy) begin
                    if (Busy) begin
                        m_saw_busy = 1'b1;
                    end else begin
                        m_quiet = m_quiet + 1;
                        if (m_quiet == 16) m_inflight = 1'b0;
                    end
                end else if (!Busy) begin
                    m_inflight = 1'b0;
                end
            end else begin
                m_strobe = (m_old_count > 0) && !Busy;
            end
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on strobes.
    always @(negedge CLK) begin
        if (checking_en) begin
            check_output("tx_valid", 32'(TX_D_VALID), 32'(m_strobe));
            check_output("q_full", 32'(Q_Full), 32'(m_count == DEPTH));
            check_output("overflow", 32'(Overflow), 32'(m_overflow));
            if (TX_D_VALID) begin
                if (exp_q.size() == 0) begin
                    fail_now("tx_data_unexpected", 32'(TX_P_Data), 32'hFFFF_FFFF);
                end else begin
                    check_output("tx_data", 32'(TX_P_Data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // UART emulator for the random phase: answers each strobe with a random
    // gap and Busy pulse, occasionally staying silent to force the timeout.
    always begin
        @(negedge CLK);
        if (uart_auto && TX_D_VALID) begin
            emu_delay  = int'($urandom_range(0, 3));
            emu_len    = int'($urandom_range(1, 6));
            emu_silent = ($urandom_range(0, 7) == 0);
            repeat (emu_delay) @(negedge CLK);
            if (!emu_silent) begin
                #1 emu_busy = 1'b1;
                repeat (emu_len) @(negedge CLK);
                #1 emu_busy = 1'b0;
            end
        end
    end

    task automatic apply_stimulus(input bit rd_v, input logic [7:0] rd_d,
                                  input bit alu_v, input logic [15:0] alu_d);
        @(negedge CLK);
        #1;
        RdData_Valid = rd_v;
        RdData       = rd_d;
        OUT_Valid    = alu_v;
        ALU_OUT      = alu_d;
        @(negedge CLK);
        #1;
        RdData_Valid = 1'b0;
        OUT_Valid    = 1'b0;
    endtask

    task automatic wait_strobe();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (TX_D_VALID) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("strobe_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake(input int n, input int hold);
        for (int k = 0; k < n; k++) begin
            wait_strobe();
            #1 man_busy = 1'b1;
            repeat (hold) @(negedge CLK);
            #1 man_busy = 1'b0;
        end
    endtask

    initial begin
        #2 RST = 1'b0;
        checking_en = 1'b1;
        repeat (3) @(negedge CLK);
        #1 RST = 1'b1;

        // First push lands on the very first edge out of reset
        RdData       = 8'hA5;
        RdData_Valid = 1'b1;
        @(negedge CLK);
        #1 RdData_Valid = 1'b0;
        handshake(1, 10);
        repeat (4) @(negedge CLK);

        // ALU pair, low byte first
        apply_stimulus(1'b0, 8'h00, 1'b1, 16'h1234);
        handshake(2, 3);
        repeat (4) @(negedge CLK);

        // Same-cycle read data and ALU result
        apply_stimulus(1'b1, 8'h0F, 1'b1, 16'hBEEF);
        handshake(3, 2);
        repeat (4) @(negedge CLK);

        // Transmitter held busy: three bytes fit, the ALU pair is dropped
        #1 man_busy = 1'b1;
        apply_stimulus(1'b1, 8'h41, 1'b0, 16'h0000);
        apply_stimulus(1'b1, 8'h42, 1'b0, 16'h0000);
        apply_stimulus(1'b1, 8'h43, 1'b0, 16'h0000);
        apply_stimulus(1'b0, 8'h00, 1'b1, 16'hCAFE);
        @(negedge CLK);
        #1 man_busy = 1'b0;
        handshake(3, 2);
        repeat (4) @(negedge CLK);

        // Busy never rises: timeout releases each byte in turn
        apply_stimulus(1'b1, 8'h51, 1'b0, 16'h0000);
        apply_stimulus(1'b1, 8'h52, 1'b0, 16'h0000);
        repeat (60) @(negedge CLK);

        // Reset while waiting for Busy to fall with bytes still queued
        apply_stimulus(1'b1, 8'h61, 1'b0, 16'h0000);
        apply_stimulus(1'b1, 8'h62, 1'b0, 16'h0000);
        apply_stimulus(1'b1, 8'h63, 1'b0, 16'h0000);
        @(negedge CLK);
        #1 man_busy = 1'b1;
        repeat (2) @(negedge CLK);
        #1 RST = 1'b0;
        repeat (2) @(negedge CLK);
        #1 RST = 1'b1;
        man_busy = 1'b0;
        repeat (30) @(negedge CLK);

        // Randomized traffic against an emulated transmitter
        uart_auto = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            #1;
            RdData_Valid = ($urandom_range(0, 5) == 0);
            RdData       = 8'($urandom);
            OUT_Valid    = ($urandom_range(0, 7) == 0);
            ALU_OUT      = 16'($urandom);
        end
        @(negedge CLK);
        #1;
        RdData_Valid = 1'b0;
        OUT_Valid    = 1'b0;

        begin
            bit drained;
            drained = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge CLK);
                if ((m_count == 0) && !m_inflight && !m_strobe) begin
                    drained = 1'b1;
                    break;
                end
            end
            if (!drained) fail_now("drain_timeout", 32'(m_count), 32'd0);
        end
        repeat (8) @(negedge CLK);
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
